// File: rtl/accel_run_sequencer.sv
// -----------------------------------------------------------------------------
// accel_run_sequencer
//
// Host-side sequencer for the TABLA accelerator memory/start/eoc interface.
// For each iteration of a job it streams pre-compiled {ctrl, data} beats from a
// valid/ready source onto the accelerator memory port. It then inserts one
// all-zero beat and pulses start. It waits for eol and pulses eoc. The
// iteration repeats until the programmed count is reached, then done pulses.
//
// Optional feature (macro ACCEL_SEQ_TIMEOUT_EN):
//   A RUN-state watchdog. After timeoutCycles cycles in RUN without eol it
//   sets the sticky err_timeout flag and ends the job via EOC -> DONE.
//   Without the macro RUN waits indefinitely and err_timeout stays 0.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   cfg_go           1-cycle pulse in IDLE: latch cfg_num_beats/cfg_num_iters
//   cfg_num_beats    load beats per iteration (0 = skip LOAD)
//   cfg_num_iters    iterations per job (0 = finish immediately)
//   abort            terminate the current job
//   s_valid/s_ready  source beat handshake
//   s_ctrl/s_data    source beat payload
//   mem_ctrl_in      accelerator memory control word (registered)
//   mem_data_input   accelerator memory data word (registered)
//   mem_rd_wrt       held 0, write only
//   start, eoc       1-cycle pulses to the accelerator
//   eol              iteration complete, from the accelerator
//   busy, done       job status; done is a 1-cycle pulse at job end
//   iter_count       iterations completed in the current job
//   err_timeout      sticky watchdog flag
//
// Handshake: a beat transfers on a rising clk edge where s_valid && s_ready.
// s_ready is high only in LOAD and never while abort or reset is high, so an
// abort always wins over a simultaneous beat. The source must hold
// s_ctrl/s_data stable while s_valid is high and no transfer has happened.
// -----------------------------------------------------------------------------
module accel_run_sequencer #(
  parameter int logNumPu         = 3,
  parameter int logNumPe         = 3,
  parameter int memDataLen       = 16,
  parameter int logMemNamespaces = 2,
  parameter int logNumMemLanes   = 4,
  parameter int timeoutCycles    = 4096,
  localparam int numMemLanes      = 1 << logNumMemLanes,
  localparam int logNumPeMemLanes = logNumPu + logNumPe - logNumMemLanes,
  localparam int memCtrlIn        = logMemNamespaces + (logNumPeMemLanes + 1) * numMemLanes,
  localparam int memDataW         = memDataLen * numMemLanes
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_go,
  input  logic [15:0]          cfg_num_beats,
  input  logic [15:0]          cfg_num_iters,
  input  logic                 abort,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [memCtrlIn-1:0] s_ctrl,
  input  logic [memDataW-1:0]  s_data,
  output logic [memCtrlIn-1:0] mem_ctrl_in,
  output logic [memDataW-1:0]  mem_data_input,
  output logic                 mem_rd_wrt,
  output logic                 start,
  output logic                 eoc,
  input  logic                 eol,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          iter_count,
  output logic                 err_timeout
);

`ifdef ACCEL_SEQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif
  localparam int TmoW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(timeoutCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_START, S_RUN, S_EOC, S_DONE
  } state_t;

  state_t                 state_q;
  logic [15:0]            num_beats_q;
  logic [15:0]            num_iters_q;
  logic [15:0]            beat_cnt_q;
  logic [15:0]            iter_q;
  logic [TmoW-1:0]        tmo_cnt_q;
  logic                   stop_q;     // end the job after the current EOC
  logic                   err_q;
  logic                   busy_q;
  logic                   start_q;
  logic                   eoc_q;
  logic                   done_q;
  logic [memCtrlIn-1:0]   mem_ctrl_q;
  logic [memDataW-1:0]    mem_data_q;

  assign s_ready        = (state_q == S_LOAD) && !abort && !reset;
  assign mem_ctrl_in    = mem_ctrl_q;
  assign mem_data_input = mem_data_q;
  assign mem_rd_wrt     = 1'b0;
  assign start          = start_q;
  assign eoc            = eoc_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign iter_count     = iter_q;
  assign err_timeout    = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      num_beats_q <= '0;
      num_iters_q <= '0;
      beat_cnt_q  <= '0;
      iter_q      <= '0;
      tmo_cnt_q   <= '0;
      stop_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      eoc_q       <= 1'b0;
      done_q      <= 1'b0;
      mem_ctrl_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      // Pulses and the memory port default to 0; a non-zero word only
      // appears in the cycle right after an accepted beat.
      start_q    <= 1'b0;
      eoc_q      <= 1'b0;
      done_q     <= 1'b0;
      mem_ctrl_q <= '0;
      mem_data_q <= '0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (cfg_go) begin
            num_beats_q <= cfg_num_beats;
            num_iters_q <= cfg_num_iters;
            beat_cnt_q  <= '0;
            iter_q      <= '0;
            stop_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b1;
            if (cfg_num_iters == 16'd0)      state_q <= S_DONE;
            else if (cfg_num_beats == 16'd0) state_q <= S_FLUSH;
            else                             state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            state_q <= S_DONE;
          end else if (s_valid) begin
            mem_ctrl_q <= s_ctrl;
            mem_data_q <= s_data;
            // 17-bit compare so a count of 65535 beats terminates cleanly.
            if (({1'b0, beat_cnt_q} + 17'd1) == {1'b0, num_beats_q}) begin
              beat_cnt_q <= '0;
              state_q    <= S_FLUSH;
            end else begin
              beat_cnt_q <= beat_cnt_q + 16'd1;
            end
          end
        end
        S_FLUSH: begin
          if (abort) begin
            state_q <= S_DONE;
          end else begin
            start_q <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          tmo_cnt_q <= '0;
          state_q   <= abort ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (abort || eol) begin
            stop_q  <= abort;
            eoc_q   <= 1'b1;
            iter_q  <= iter_q + 16'd1;
            state_q <= S_EOC;
          end else if (TmoEn && (tmo_cnt_q == TmoLast)) begin
            err_q   <= 1'b1;
            stop_q  <= 1'b1;
            eoc_q   <= 1'b1;
            iter_q  <= iter_q + 16'd1;
            state_q <= S_EOC;
          end else if (TmoEn) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_EOC: begin
          // iter_q already holds the incremented count here.
          if (stop_q || abort || (iter_q >= num_iters_q)) state_q <= S_DONE;
          else if (num_beats_q == 16'd0)                  state_q <= S_FLUSH;
          else                                            state_q <= S_LOAD;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accel_run_sequencer.sv
// -----------------------------------------------------------------------------
// tb_accel_run_sequencer
//
// Directed bench. Drivers push expected events {type, cycle, payload} into
// exp_q as stimulus is issued (beats on acceptance, start/eoc/done at
// hand-computed cycles). A negedge monitor pops and compares whenever the DUT
// shows a beat, start, eoc or done. Cycle k is the cycle after the k-th edge
// following the edge that sampled cfg_go.
// -----------------------------------------------------------------------------
module tb_accel_run_sequencer;
  localparam int CW = 50;
  localparam int DW = 256;
  localparam int EW = 3 + 32 + CW;
  localparam logic [2:0] EV_BEAT = 3'd1, EV_START = 3'd2, EV_EOC = 3'd3, EV_DONE = 3'd4;
`ifdef ACCEL_SEQ_TIMEOUT_EN
  localparam int TMO = 64;
`else
  localparam int TMO = 4096;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          cfg_go = 1'b0;
  logic [15:0]   cfg_num_beats = '0;
  logic [15:0]   cfg_num_iters = '0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [CW-1:0] s_ctrl = '0;
  logic [DW-1:0] s_data = '0;
  logic [CW-1:0] mem_ctrl_in;
  logic [DW-1:0] mem_data_input;
  logic          mem_rd_wrt;
  logic          start;
  logic          eoc;
  logic          eol = 1'b0;
  logic          busy;
  logic          done;
  logic [15:0]   iter_count;
  logic          err_timeout;

  accel_run_sequencer #(.timeoutCycles(TMO)) u_dut (
    .clk(clk), .reset(reset), .cfg_go(cfg_go),
    .cfg_num_beats(cfg_num_beats), .cfg_num_iters(cfg_num_iters),
    .abort(abort), .s_valid(s_valid), .s_ready(s_ready),
    .s_ctrl(s_ctrl), .s_data(s_data),
    .mem_ctrl_in(mem_ctrl_in), .mem_data_input(mem_data_input),
    .mem_rd_wrt(mem_rd_wrt), .start(start), .eoc(eoc), .eol(eol),
    .busy(busy), .done(done), .iter_count(iter_count), .err_timeout(err_timeout)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] exp_d_q[$];

  function automatic logic [EW-1:0] ev(input logic [2:0] t, input int unsigned at,
                                       input logic [CW-1:0] p);
    return {t, at[31:0], p};
  endfunction

  function automatic logic [CW-1:0] beat_ctrl(input int tag, input int i);
    return {2'b01, tag[15:0], i[15:0], 16'hA5A5};
  endfunction

  function automatic logic [DW-1:0] beat_data(input int tag, input int i);
    logic [CW-1:0] c;
    c = beat_ctrl(tag, i);
    return {8{c[31:0] ^ 32'h5A00_0000}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [EW-1:0] act);
    logic [EW-1:0] e;
    logic [DW-1:0] d;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %0h at cycle %0d, nothing expected", name, act, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        errors++;
        $display("FAIL %s: got event %0h expected %0h", name, act, e);
      end
      if (e[EW-1 -: 3] == EV_BEAT && exp_d_q.size() > 0) begin
        d = exp_d_q.pop_front();
        check("beat data", mem_data_input, d);
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_ctrl_in != '0 || mem_data_input != '0)
        pop_cmp("beat", ev(EV_BEAT, cyc, mem_ctrl_in));
      if (start) pop_cmp("start", ev(EV_START, cyc, '0));
      if (eoc)   pop_cmp("eoc", ev(EV_EOC, cyc, CW'(iter_count)));
      if (done)  pop_cmp("done", ev(EV_DONE, cyc, CW'(iter_count)));
    end
  end

  // driver tasks (all entered and left at a negedge)
  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic go(input int beats, input int iters, output int unsigned g0);
    cfg_num_beats = beats[15:0];
    cfg_num_iters = iters[15:0];
    cfg_go = 1'b1;
    g0 = cyc + 1;
    @(negedge clk);
    cfg_go = 1'b0;
  endtask

  // mode 0: s_valid always 1; mode 1: s_valid toggles 1/0
  task automatic load_beats(input int n, input int mode, input int tag);
    int got;
    int slot;
    bit acc;
    got = 0;
    slot = 0;
    while (got < n && slot < 1000) begin
      s_valid = (mode == 0) ? 1'b1 : ((slot % 2) == 0);
      s_ctrl  = beat_ctrl(tag, got);
      s_data  = beat_data(tag, got);
      #1;
      acc = s_valid && s_ready;
      if (acc) begin
        exp_q.push_back(ev(EV_BEAT, cyc + 1, s_ctrl));
        exp_d_q.push_back(s_data);
      end
      @(negedge clk);
      if (acc) got++;
      slot++;
    end
    s_valid = 1'b0;
    s_ctrl  = '0;
    s_data  = '0;
    check("accepted beats", DW'(got), DW'(n));
  endtask

  // eol in cycle s+w: eoc at s+w+1, done (if last) at s+w+3, next LOAD at s+w+2
  task automatic finish_iter(input int unsigned s, input int w, input bit last,
                             input int it, output int unsigned nb);
    wait_until(s + w);
    eol = 1'b1;
    exp_q.push_back(ev(EV_EOC, s + w + 1, CW'(it)));
    if (last) exp_q.push_back(ev(EV_DONE, s + w + 3, CW'(it)));
    @(negedge clk);
    eol = 1'b0;
    @(negedge clk);
    nb = s + w + 2;
  endtask

  task automatic run_iter(input int beats, input int mode, input int tag, input int start_off,
                          input int w, input bit last, input int it,
                          input int unsigned b, output int unsigned nb);
    if (beats > 0) load_beats(beats, mode, tag);
    exp_q.push_back(ev(EV_START, b + start_off, '0));
    finish_iter(b + start_off, w, last, it, nb);
  endtask

  initial begin
    int unsigned g;
    int unsigned nb;
    int unsigned nb2;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst mem_ctrl_in", DW'(mem_ctrl_in), '0);
    check("rst mem_data_input", mem_data_input, '0);
    check("rst s_ready", DW'(s_ready), '0);
    check("rst start", DW'(start), '0);
    check("rst eoc", DW'(eoc), '0);
    check("rst busy", DW'(busy), '0);
    check("rst done", DW'(done), '0);
    check("rst iter_count", DW'(iter_count), '0);
    check("rst err_timeout", DW'(err_timeout), '0);
    check("rst mem_rd_wrt", DW'(mem_rd_wrt), '0);
    @(negedge clk);

    // basic: 8 beats, 1 iteration, eol 100 cycles after start
    go(8, 1, g);
    load_beats(8, 0, 1);
    exp_q.push_back(ev(EV_START, g + 9, '0));
    wait_until(g + 20);
    check("busy in run", DW'(busy), DW'(1));
    check("s_ready in run", DW'(s_ready), '0);
    cfg_num_iters = 16'd0;                 // cfg_go while busy must be ignored
    cfg_go = 1'b1;
    @(negedge clk);
    cfg_go = 1'b0;
    finish_iter(g + 9, 100, 1'b1, 1, nb);
    wait_until(g + 113);
    check("basic busy after done", DW'(busy), '0);
    check("basic iter_count", DW'(iter_count), DW'(1));

    // backpressure: 4 beats with s_valid toggling; start at k=8
    go(4, 1, g);
    run_iter(4, 1, 2, 8, 10, 1'b1, 1, g, nb);
    wait_until(nb + 3);

    // multi-iteration: second load right after eoc
    go(8, 2, g);
    run_iter(8, 0, 3, 9, 20, 1'b0, 1, g, nb);
    run_iter(8, 0, 4, 9, 20, 1'b1, 2, nb, nb2);
    wait_until(nb2 + 3);
    check("multi iter_count", DW'(iter_count), DW'(2));

    // iters=0: done 2 cycles after cfg_go, iter_count cleared
    go(5, 0, g);
    exp_q.push_back(ev(EV_DONE, g + 1, CW'(0)));
    wait_until(g + 4);
    check("iters0 busy", DW'(busy), '0);

    // beats=0: start 2 cycles after cfg_go
    go(0, 1, g);
    run_iter(0, 0, 0, 1, 5, 1'b1, 1, g, nb);
    wait_until(nb + 3);

    // abort in LOAD after 3 beats, with a beat offered at the same time
    go(8, 1, g);
    load_beats(3, 0, 5);
    abort   = 1'b1;
    s_valid = 1'b1;
    s_ctrl  = beat_ctrl(5, 3);
    s_data  = beat_data(5, 3);
    exp_q.push_back(ev(EV_DONE, g + 5, CW'(0)));
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    s_ctrl  = '0;
    s_data  = '0;
    wait_until(g + 8);
    check("abort load busy", DW'(busy), '0);

    // abort in RUN together with eol, iterations remaining: eoc then done
    go(2, 3, g);
    load_beats(2, 0, 6);
    exp_q.push_back(ev(EV_START, g + 3, '0));
    wait_until(g + 10);
    abort = 1'b1;
    eol   = 1'b1;
    exp_q.push_back(ev(EV_EOC, g + 11, CW'(1)));
    exp_q.push_back(ev(EV_DONE, g + 13, CW'(1)));
    @(negedge clk);
    abort = 1'b0;
    eol   = 1'b0;
    wait_until(g + 16);
    check("abort run iter_count", DW'(iter_count), DW'(1));
    check("abort run busy", DW'(busy), '0);

    // reset in RUN: everything 0 at the next edge, no eoc
    go(1, 1, g);
    load_beats(1, 0, 7);
    exp_q.push_back(ev(EV_START, g + 2, '0));
    wait_until(g + 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rrun busy", DW'(busy), '0);
    check("rrun iter_count", DW'(iter_count), '0);
    check("rrun mem_ctrl_in", DW'(mem_ctrl_in), '0);
    check("rrun start", DW'(start), '0);
    check("rrun eoc", DW'(eoc), '0);
    check("rrun done", DW'(done), '0);
    check("rrun s_ready", DW'(s_ready), '0);
    eol = 1'b1;                            // eol in IDLE must be ignored
    @(negedge clk);
    eol = 1'b0;
    repeat (4) @(negedge clk);

`ifdef ACCEL_SEQ_TIMEOUT_EN
    // watchdog: eol never comes; 64 RUN cycles then eoc, done
    go(0, 3, g);
    exp_q.push_back(ev(EV_START, g + 1, '0));
    exp_q.push_back(ev(EV_EOC, g + 66, CW'(1)));
    exp_q.push_back(ev(EV_DONE, g + 68, CW'(1)));
    wait_until(g + 70);
    check("timeout err sticky", DW'(err_timeout), DW'(1));
    go(3, 0, g);
    exp_q.push_back(ev(EV_DONE, g + 1, CW'(0)));
    check("timeout err cleared", DW'(err_timeout), '0);
    wait_until(g + 4);
`endif

    repeat (5) @(negedge clk);
    check("events outstanding", DW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
